uart_cmd_assembler: RTL and testbench
=====================================

# uart_cmd_assembler

Command-framing controller that sits between the UART receiver and the command processor. It consumes received bytes through the receiver's `rdy`/`clr_rdy` handshake and pairs them high-byte-then-low-byte into 16-bit commands. It presents each command with a held ready flag, and recovers framing after an inter-byte timeout. Overruns are flagged when a new command completes before the previous one has been taken.

## Interface
- `TIMEOUT`, default 100000: number of clk cycles allowed in WAIT_LO without a byte before the partial command is abandoned (≈4 byte times at 50 MHz / 19200 baud).
- `TO_W`, default 17: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT.

Ports:
- `clk` in 1: system clock; every flop is on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `rx_rdy` in 1: byte-ready from the UART receiver. Held high until cleared.
- `rx_data` in 8: received byte. Valid while `rx_rdy`=1.
- `clr_rx_rdy` out 1: consume strobe to the receiver's `clr_rdy`. Combinational, equal to `rx_rdy`.
- `clr_cmd_rdy` in 1: consumer acknowledge. Clears `cmd_rdy` and `overrun`.
- `cmd` out 16: assembled command, registered. Changes only on completion.
- `cmd_rdy` out 1: command valid, registered. Held until acknowledged.
- `overrun` out 1: sticky, registered. Set when a completed command overwrote an unacknowledged one.
- `to_err` out 1: registered one-cycle pulse on inter-byte timeout.

## Operation
- State machine, 2 states:
  - **WAIT_HI** (reset state). When `rx_rdy`=1, capture `rx_data` into the internal `hi_byte` register, clear the timeout counter, and go to WAIT_LO.
  - **WAIT_LO**. When `rx_rdy`=1: `cmd` ← {`hi_byte`, `rx_data`}, set `cmd_rdy`, go to WAIT_HI. Otherwise, when the counter equals `TIMEOUT`: pulse `to_err`, discard `hi_byte`, go to WAIT_HI. Otherwise the counter increments by 1.
- Byte consumption:
  - Every byte is consumed in every state. Bytes are never stalled or dropped at the UART side.
  - `clr_rx_rdy` = `rx_rdy` in the same cycle. The receiver drops `rdy` on the next edge, so each byte is consumed exactly once.
- The timeout counter is `TO_W` bits wide. It is cleared on high-byte capture and is held (not counting) in WAIT_HI. It never wraps because it exits at `TIMEOUT`.
- `cmd_rdy` / `overrun` update, evaluated each edge:
  - Completion with `cmd_rdy`=1 and `clr_cmd_rdy`=0: `cmd` is overwritten, `cmd_rdy` stays 1, `overrun` ← 1.
  - Completion with `clr_cmd_rdy`=1: `cmd_rdy` stays 1 and `overrun` ← 0. The acknowledge applies to the old command; the new one is pending.
  - `clr_cmd_rdy`=1 with no completion: `cmd_rdy` ← 0, `overrun` ← 0.
- Boundary cases:
  - Byte arrival and counter == `TIMEOUT` in the same cycle: the byte wins. It completes the command and there is no `to_err`.
  - A high byte arriving while `cmd_rdy`=1 is accepted normally. `cmd` is not disturbed until the low byte arrives.
  - Reset mid-command: `hi_byte` is lost and the FSM restarts in WAIT_HI.

## Timing
- Reset values: `cmd`=16'h0000, `cmd_rdy`=0, `overrun`=0, `to_err`=0, state=WAIT_HI, counter=0, `hi_byte`=8'h00. `clr_rx_rdy` follows `rx_rdy`, which is 0 out of reset.
- Latency: low byte seen with `rx_rdy` high in cycle N gives `cmd` and `cmd_rdy` valid from cycle N+1.
- Timeout: high byte captured at edge E gives the `to_err` pulse in cycle E+`TIMEOUT`+1 and WAIT_HI from that same cycle, provided no byte arrives in between.
- `cmd_rdy` falls on the edge after `clr_cmd_rdy` is sampled high (unless a completion occurs in that cycle).
- `cmd` is stable for the whole time `cmd_rdy` is high, except when an overrun overwrite occurs.

## Test plan
- **Basic pair.** Bytes 0xA5 then 0x3C, with `clr_cmd_rdy` low. Expect `clr_rx_rdy` high for exactly one cycle per byte. Expect `cmd`=16'hA53C and `cmd_rdy`=1 one cycle after the second `rx_rdy`, with `overrun`=0.
- **Acknowledge.** Pulse `clr_cmd_rdy` after the basic pair. Expect `cmd_rdy`=0 on the next cycle and `cmd` still 16'hA53C.
- **Overrun.** Send 0x12,0x34 then 0x56,0x78 with no acknowledge. Expect `cmd`=16'h5678, `cmd_rdy`=1, `overrun`=1. After `clr_cmd_rdy`, expect both flags 0.
- **Timeout resync.** Set `TIMEOUT`=50. Send 0xFF, wait 60 cycles, then send 0x01,0x02. Expect one `to_err` pulse exactly 51 cycles after the 0xFF capture, then `cmd`=16'h0102 (not 16'hFF01).
- **Simultaneous events.** Low byte arrives on the cycle the counter equals `TIMEOUT`: expect the command to complete with no `to_err`. Completion coinciding with `clr_cmd_rdy`: expect `cmd_rdy` to stay 1 and `overrun`=0.
- **Reset mid-frame.** Assert `rst_n`=0 after the high byte 0xAB, then send 0xCD,0xEF. Expect all outputs at reset values during reset, then `cmd`=16'hCDEF.

Source files
------------

// File: rtl/uart_cmd_assembler.sv
// Pairs UART bytes (high then low) into 16-bit commands with a held ready flag,
// sticky overrun and an inter-byte timeout that resynchronises framing.
module uart_cmd_assembler #(
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned TO_W    = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        overrun,
  output logic        to_err
);

  typedef enum logic {WAIT_HI, WAIT_LO} state_t;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic [7:0]      hi_byte, hi_byte_nxt;
  logic [15:0]     cmd_nxt;
  logic            cmd_rdy_nxt, overrun_nxt, to_err_nxt;
  logic            done;

  // Every byte is consumed immediately; the receiver never sees back-pressure.
  assign clr_rx_rdy = rx_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_HI;
      to_cnt  <= '0;
      hi_byte <= '0;
      cmd     <= '0;
      cmd_rdy <= 1'b0;
      overrun <= 1'b0;
      to_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      to_cnt  <= to_cnt_nxt;
      hi_byte <= hi_byte_nxt;
      cmd     <= cmd_nxt;
      cmd_rdy <= cmd_rdy_nxt;
      overrun <= overrun_nxt;
      to_err  <= to_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    to_cnt_nxt  = to_cnt;
    hi_byte_nxt = hi_byte;
    cmd_nxt     = cmd;
    to_err_nxt  = 1'b0;
    done        = 1'b0;

    case (state)
      WAIT_HI: begin
        if (rx_rdy) begin
          hi_byte_nxt = rx_data;
          to_cnt_nxt  = '0;
          state_nxt   = WAIT_LO;
        end
      end
      WAIT_LO: begin
        // A byte arriving on the timeout cycle still completes the command.
        if (rx_rdy) begin
          cmd_nxt   = {hi_byte, rx_data};
          done      = 1'b1;
          state_nxt = WAIT_HI;
        end else if (to_cnt == TO_MAX) begin
          to_err_nxt  = 1'b1;
          hi_byte_nxt = '0;
          state_nxt   = WAIT_HI;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      default: state_nxt = WAIT_HI;
    endcase

    cmd_rdy_nxt = cmd_rdy;
    overrun_nxt = overrun;
    if (done) begin
      // An acknowledge coinciding with completion retires the old command only.
      cmd_rdy_nxt = 1'b1;
      overrun_nxt = clr_cmd_rdy ? 1'b0 : (overrun | cmd_rdy);
    end else if (clr_cmd_rdy) begin
      cmd_rdy_nxt = 1'b0;
      overrun_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed and random stimulus for uart_cmd_assembler, checked each cycle
// against a byte-queue reference model.
module tb_uart_cmd_assembler;

  localparam int unsigned TO = 50;

  logic        clk;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        overrun;
  logic        to_err;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned n_to     = 0;

  // Reference model: pending high byte kept in a queue, idle age since capture.
  logic [7:0]  m_q[$];
  int unsigned m_age;
  logic [15:0] m_cmd;
  logic        m_rdy, m_ov, m_to;

  uart_cmd_assembler #(.TIMEOUT(TO), .TO_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .overrun     (overrun),
    .to_err      (to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_age = 0;
    m_cmd = 16'h0000;
    m_rdy = 1'b0;
    m_ov  = 1'b0;
    m_to  = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b, input logic clr);
    logic completed;
    completed = 1'b0;
    m_to = 1'b0;
    if (v) begin
      if (m_q.size() == 0) begin
        m_q.push_back(b);
        m_age = 0;
      end else begin
        m_cmd = {m_q.pop_front(), b};
        completed = 1'b1;
      end
    end else if (m_q.size() == 1) begin
      if (m_age == TO) begin
        m_q.delete();
        m_to = 1'b1;
      end else begin
        m_age++;
      end
    end
    if (completed) begin
      m_ov  = clr ? 1'b0 : (m_rdy | m_ov);
      m_rdy = 1'b1;
    end else if (clr) begin
      m_rdy = 1'b0;
      m_ov  = 1'b0;
    end
  endtask

  task automatic check_outputs(input string phase);
    chk({phase, ".cmd"},     cmd,             m_cmd);
    chk({phase, ".cmd_rdy"}, {15'd0, cmd_rdy}, {15'd0, m_rdy});
    chk({phase, ".overrun"}, {15'd0, overrun}, {15'd0, m_ov});
    chk({phase, ".to_err"},  {15'd0, to_err},  {15'd0, m_to});
  endtask

  // One clock: drive at negedge, check the consume strobe, then check the
  // registered outputs just after the rising edge.
  task automatic cycle(input logic v, input logic [7:0] b, input logic clr);
    @(negedge clk);
    rx_rdy      = v;
    rx_data     = v ? b : 8'h00;
    clr_cmd_rdy = clr;
    #1;
    chk("clr_rx_rdy", {15'd0, clr_rx_rdy}, {15'd0, v});
    @(posedge clk);
    model_step(v, b, clr);
    #1;
    if (to_err) n_to++;
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    rx_rdy      = 1'b0;
    rx_data     = 8'h00;
    clr_cmd_rdy = 1'b0;
    model_reset();
    #1;
    check_outputs("rst");
    chk("rst.clr_rx_rdy", {15'd0, clr_rx_rdy}, 16'd0);
    repeat (2) @(negedge clk);
    check_outputs("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b1;
    rx_rdy      = 1'b0;
    rx_data     = 8'h00;
    clr_cmd_rdy = 1'b0;
    do_reset();

    // Basic pair and acknowledge
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0);
    chk("basic.cmd", cmd, 16'hA53C);
    chk("basic.rdy", {15'd0, cmd_rdy}, 16'd1);
    chk("basic.ov",  {15'd0, overrun}, 16'd0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("ack.rdy", {15'd0, cmd_rdy}, 16'd0);
    chk("ack.cmd", cmd, 16'hA53C);

    // Overrun
    cycle(1'b1, 8'h12, 1'b0);
    cycle(1'b1, 8'h34, 1'b0);
    cycle(1'b1, 8'h56, 1'b0);
    cycle(1'b1, 8'h78, 1'b0);
    chk("ovr.cmd", cmd, 16'h5678);
    chk("ovr.ov",  {15'd0, overrun}, 16'd1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("ovr_ack.rdy", {15'd0, cmd_rdy}, 16'd0);
    chk("ovr_ack.ov",  {15'd0, overrun}, 16'd0);

    // Timeout resync: pulse lands exactly TO+1 cycles after capture
    n_to = 0;
    cycle(1'b1, 8'hFF, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      chk("to.pulse_at", {15'd0, to_err}, {15'd0, (i == TO + 1)});
    end
    chk("to.count", 16'(n_to), 16'd1);
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h02, 1'b0);
    chk("to.cmd", cmd, 16'h0102);

    // Low byte on the timeout cycle wins; completion coincides with ack
    n_to = 0;
    cycle(1'b1, 8'h9A, 1'b0);
    repeat (TO) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'hBC, 1'b1);
    chk("sim.cmd", cmd, 16'h9ABC);
    chk("sim.rdy", {15'd0, cmd_rdy}, 16'd1);
    chk("sim.ov",  {15'd0, overrun}, 16'd0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("sim.no_to", 16'(n_to), 16'd0);

    // Reset mid-frame
    cycle(1'b1, 8'hAB, 1'b0);
    do_reset();
    cycle(1'b1, 8'hCD, 1'b0);
    cycle(1'b1, 8'hEF, 1'b0);
    chk("rstmid.cmd", cmd, 16'hCDEF);

    // Random traffic with occasional long gaps to provoke timeouts
    for (int i = 0; i < 300; i++) begin
      int unsigned gap;
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 60) : $urandom_range(0, 2);
      repeat (gap) cycle(1'b0, 8'h00, ($urandom_range(0, 7) == 0));
      cycle(1'b1, 8'($urandom), ($urandom_range(0, 5) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
